// File: rtl/md_pkg.sv
// md_pkg: opcode encodings, default sizes and op-class helpers for the multiply/divide unit
package md_pkg;
    localparam int MD_WIDTH       = 32;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    function automatic logic md_is_mul(input logic [3:0] op);
        return op == MD_MULT || op == MD_MULTU;
    endfunction
    function automatic logic md_is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational product/quotient/remainder for one mult/div operation
module md_compute import md_pkg::*; #(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_a2,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo,
    output logic             o_div_by_zero
);
    logic signed [2*WIDTH-1:0] w_sprod;
    logic        [2*WIDTH-1:0] w_uprod;
    logic                      w_zero;
    logic                      w_ovf;
    logic        [WIDTH-1:0]   w_sden;
    logic        [WIDTH-1:0]   w_uden;
    logic signed [WIDTH-1:0]   w_squo;
    logic signed [WIDTH-1:0]   w_srem;
    logic        [WIDTH-1:0]   w_uquo;
    logic        [WIDTH-1:0]   w_urem;
    assign w_sprod = $signed({{WIDTH{i_a1[WIDTH-1]}}, i_a1}) * $signed({{WIDTH{i_a2[WIDTH-1]}}, i_a2});
    assign w_uprod = {{WIDTH{1'b0}}, i_a1} * {{WIDTH{1'b0}}, i_a2};
    assign w_zero  = i_a2 == '0;
    assign w_ovf   = i_a1 == {1'b1, {(WIDTH-1){1'b0}}} && &i_a2;
    // Dividing by 1 instead of -1 yields exactly the wrapped MIN quotient with a zero remainder
    assign w_sden  = (w_zero || w_ovf) ? WIDTH'(1) : i_a2;
    assign w_uden  = w_zero ? WIDTH'(1) : i_a2;
    assign w_squo  = $signed(i_a1) / $signed(w_sden);
    assign w_srem  = $signed(i_a1) % $signed(w_sden);
    assign w_uquo  = i_a1 / w_uden;
    assign w_urem  = i_a1 % w_uden;
    assign o_div_by_zero = md_is_div(i_op) && w_zero;
    always_comb begin
        o_res_hi = i_op == MD_MULT  ? w_sprod[2*WIDTH-1:WIDTH] :
                   i_op == MD_MULTU ? w_uprod[2*WIDTH-1:WIDTH] :
                   i_op == MD_DIV   ? w_srem :
                   i_op == MD_DIVU  ? w_urem : '0;
        o_res_lo = i_op == MD_MULT  ? w_sprod[WIDTH-1:0] :
                   i_op == MD_MULTU ? w_uprod[WIDTH-1:0] :
                   i_op == MD_DIV   ? w_squo :
                   i_op == MD_DIVU  ? w_uquo : '0;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO and a busy interlock
module md_unit import md_pkg::*; #(
    parameter int WIDTH       = MD_WIDTH,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_res
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_dz;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_dz;
    logic             w_busy;
    md_compute #(.WIDTH(WIDTH)) u_compute (
        .i_a1          (A1),
        .i_a2          (A2),
        .i_op          (md_op),
        .o_res_hi      (w_res_hi),
        .o_res_lo      (w_res_lo),
        .o_div_by_zero (w_dz)
    );
    assign w_busy = r_cnt != '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
            r_cnt     <= '0;
        end else if (w_busy) begin
            // Any start during busy falls through here and is dropped
            if (r_cnt == CW'(1) && !r_pend_dz) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            r_cnt <= r_cnt - CW'(1);
        end else if (start) begin
            if (md_is_mul(md_op) || md_is_div(md_op)) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_dz <= w_dz;
                r_cnt     <= md_is_mul(md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (md_op == MD_MTHI) begin
                r_hi <= A1;
            end else if (md_op == MD_MTLO) begin
                r_lo <= A1;
            end
        end
    end
    always_comb begin
        md_res = md_op == MD_MFHI ? r_hi : md_op == MD_MFLO ? r_lo : '0;
    end
    assign busy = w_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model
module tb_md_unit;
    import md_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = MD_NONE;
    logic [31:0] A1 = '0;
    logic [31:0] A2 = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_res;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A1     (A1),
        .A2     (A2),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_res (md_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] cur);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        case (op)
            MD_MULT:  begin p = sa * sb; return p; end
            MD_MULTU: begin p = ua * ub; return p; end
            MD_DIV:   return b == 0 ? cur : {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  return b == 0 ? cur : {32'(ua % ub), 32'(ua / ub)};
            MD_MTHI:  return {a, cur[31:0]};
            MD_MTLO:  return {cur[63:32], a};
            default:  return cur;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (op == MD_MULT || op == MD_MULTU) ? 5 : (op == MD_DIV || op == MD_DIVU) ? 10 : 0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [3:0] op);
        return op == MD_MFHI ? m_hi : op == MD_MFLO ? m_lo : 32'd0;
    endfunction

    // Issue one op, watch busy for its full latency while optionally poking ignored starts, then check HI/LO
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic inject);
        logic [63:0] exp = ref_md(op, a, b, {m_hi, m_lo});
        int n = ref_lat(op);
        @(negedge clk);
        start = 1'b1; md_op = op; A1 = a; A2 = b;
        #1 check("md_res_issue", md_res, ref_rd(op));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("busy_high", {31'd0, busy}, 32'd1);
            start = inject; md_op = 4'($urandom_range(0, 15)); A1 = $urandom; A2 = $urandom;
            #1 check("md_res_busy", md_res, ref_rd(md_op));
        end
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        check("busy_low", {31'd0, busy}, 32'd0);
        check("hi", hi, exp[63:32]);
        check("lo", lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_md_res", md_res, 32'd0);
        md_op = MD_MFHI;
        #1 check("rst_mfhi", md_res, 32'd0);

        run(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFA);
        run(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi_const", hi, 32'h0000_0002);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        run(MD_DIVU,  32'd7, 32'd2, 1'b0);
        run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo_const", lo, 32'h8000_0000);
        run(MD_MTHI,  32'h11, 32'd0, 1'b0);
        run(MD_MTLO,  32'h22, 32'd0, 1'b0);
        run(MD_DIV,   32'h1234, 32'd0, 1'b1);
        check("dz_hi_const", hi, 32'h11);
        check("dz_lo_const", lo, 32'h22);
        run(MD_DIVU,  32'h1234, 32'd0, 1'b0);
        run(MD_MTHI,  32'd0, 32'd0, 1'b0);
        run(MD_MTLO,  32'd0, 32'd0, 1'b0);
        run(MD_MULT,  32'd3, 32'd4, 1'b1);
        check("ign_lo_const", lo, 32'd12);
        run(MD_MULTU, 32'h1_0000, 32'h1_0000, 1'b0);
        run(MD_DIVU,  32'd9, 32'd4, 1'b0);
        md_op = MD_MFLO;
        #1 check("mflo", md_res, 32'd2);
        md_op = MD_MFHI;
        #1 check("mfhi", md_res, 32'd1);
        md_op = MD_NONE;

        @(negedge clk);
        start = 1'b1; md_op = MD_DIV; A1 = 32'd100; A2 = 32'd7;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0; md_op = MD_NONE;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_mid_hi_late", hi, 32'd0);
        check("rst_mid_lo_late", lo, 32'd0);

        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                3: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers; the sequential companion to the single-cycle ALU in the EX stage of the 5-stage pipeline.
- Implements mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Width and per-operation latencies are parametrised.
- Raises busy while an operation is in flight so the hazard unit can stall any later MD instruction.

Parameters:
WIDTH, 32, operand width and width of HI and LO
MULT_CYCLES, 5, busy cycles for mult/multu; must be >= 1
DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue strobe; op sampled on the rising edge where start=1
md_op  input  4  operation code; encodings in md_pkg
A1  input  WIDTH  rs operand: dividend or multiplicand, or the value written by mthi/mtlo
A2  input  WIDTH  rt operand: divisor or multiplier
busy  output  1  1 while a mult/div is pending
hi  output  WIDTH  current HI
lo  output  WIDTH  current LO
md_res  output  WIDTH  combinational: hi when md_op=MFHI, lo when md_op=MFLO, else 0

Behaviour:
- Reset (synchronous, has priority over everything):
  - hi, lo, internal counter and pending registers all clear to 0.
  - busy=0.
  - An in-flight operation is discarded; HI/LO stay 0.
- Opcodes:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Codes 9..15 behave as NONE.
- Accept rule: start is accepted only when busy=0. start while busy=1 is ignored and has no side effect. Upstream must stall on (start & MD-type) | busy.
- mult/div accept, at edge T:
  - Operands are latched and the result is computed into pend_hi/pend_lo.
  - counter <= N, where N=MULT_CYCLES or DIV_CYCLES.
  - busy = (counter != 0), so busy is high for exactly N cycles after edge T.
  - On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, counter<=0.
  - New HI/LO and busy=0 therefore become visible together in the cycle after edge T+N.
- MULT: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- MULTU: same split, unsigned operands.
- DIV (signed):
  - lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - Most-negative / -1: lo=most-negative value (wraps), hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero, signed or unsigned:
  - The operation still runs and busy is held for DIV_CYCLES.
  - At completion hi and lo are left unchanged.
- MTHI/MTLO:
  - Accepted only when busy=0; on that edge hi<=A1 (or lo<=A1).
  - Single cycle, busy stays 0.
  - Ignored while busy.
- MFHI/MFLO:
  - Purely combinational read through md_res; no state change; does not require start.
  - Reading while busy returns the old value; the hazard unit must stall.
- Back-to-back: start may be accepted in the first cycle busy=0 after completion and sees the freshly written HI/LO.

Decomposition:
- Package md_pkg holds:
  - md_op encodings as localparams: MD_NONE .. MD_MFLO, width 4.
  - Default latency constants.
- One sub-module, md_compute: purely combinational, takes A1, A2 and op, returns {res_hi, res_lo, div_by_zero}.
- md_unit holds the counter, pending registers, HI/LO and the control logic.

Test Plan:
- Reset sequence: hold reset 2 cycles -> hi=0, lo=0, busy=0, md_res=0. Assert reset at counter=3 of a DIV -> busy=0 on the next cycle, hi=lo=0.
- MULT: A1=0xFFFFFFFE (-2), A2=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - A1=-7 (0xFFFFFFF9), A2=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 -> lo=3, hi=1.
  - 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV A2=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Start while busy: MULT 3*4, then a second start with MTHI A1=0xDEAD during busy -> ignored; final hi=0, lo=12; busy length unchanged.
- Back-to-back and read: MULTU 0x10000*0x10000, then DIVU 9/4 on the first free cycle -> first yields hi=1, lo=0; second yields lo=2, hi=1. md_op=MFLO reads md_res=2 and md_op=MFHI reads md_res=1.
